neuron_vec_loader: RTL and testbench
====================================

Name: neuron_vec_loader

Overview:
Streaming front end for the combinational neuron. It accepts one signed WIDTH-bit input element per cycle over a valid/ready stream and assembles N elements into a parallel vector. It presents that vector, with its own valid/ready handshake, to the neuron's in[0:N-1] port. Two banks are used (ping-pong), so one vector can be filled while the other is held for the neuron.

Parameters:
WIDTH, 16, bit width of each signed input element (same as the neuron's WIDTH).
N, 8, number of elements per vector (same as the neuron's N).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  reset: asynchronous, active-high.
s_valid  input  1  upstream element valid.
s_ready  output  1  loader can accept an element this cycle.
s_data  input  WIDTH  signed element.
s_last  input  1  marks the final element of a vector (sampled only on accept).
m_valid  output  1  a complete vector is presented on m_vec.
m_ready  input  1  downstream (neuron-side) has consumed m_vec.
m_vec  output  N x WIDTH  unpacked signed array [0:N-1]; element 0 is the first element accepted.
len_err  output  1  one-cycle pulse: s_last placement did not match N.
fill_idx  output  $clog2(N)  index the next accepted element will occupy (debug).

Behaviour:
- Reset (async assert, clock-synchronous release) sets:
  - both banks to all zeros and both bank_full flags to 0;
  - fill_bank=0, out_bank=0, fill_idx=0;
  - s_ready=1, m_valid=0, len_err=0.
- Reset mid-vector discards all partial and complete vectors.
- Element accept happens when s_valid && s_ready:
  - buf[fill_bank][fill_idx] <= s_data;
  - fill_idx increments by 1.
- Vector completion happens on an accept with fill_idx==N-1, or an accept with s_last=1:
  - bank_full[fill_bank] <= 1;
  - fill_bank toggles;
  - fill_idx <= 0.
- Short vector (s_last=1 at fill_idx<N-1):
  - entries fill_idx+1..N-1 of that bank are written 0 in the same cycle;
  - the bank is marked full;
  - len_err pulses on the next cycle.
- Long vector (fill_idx==N-1 with s_last=0):
  - the vector completes normally and len_err pulses;
  - the next element starts a new vector.
- Backpressure and output:
  - s_ready = !bank_full[fill_bank] (combinational from registers).
  - m_valid = bank_full[out_bank]; m_vec = buf[out_bank].
  - m_vec must stay stable while m_valid && !m_ready.
- Drain happens when m_valid && m_ready: bank_full[out_bank] <= 0 and out_bank toggles.
- Simultaneous completion of the fill bank and drain of the out bank in the same cycle:
  - both take effect;
  - they never address the same bank, because s_ready is low when the fill bank is full.
- Latency: first element accepted in cycle k, last in cycle k+N-1, m_valid high in cycle k+N.
- Throughput: one vector per N cycles sustained when m_ready is held high; no bubbles between vectors.
- Full condition: both banks full gives s_ready=0. The first drain re-enables s_ready on the next cycle.
- Empty condition: m_valid=0 and m_vec shows the last contents of out_bank (zeros after reset).
- No arithmetic is performed; data passes bit-exact and signed.

Decomposition:
- neuron_pkg (shared package) holds:
  - default constants NEURON_WIDTH=16 and NEURON_N=8;
  - typedef elem_t (logic signed [WIDTH-1:0]);
  - a vector type for [0:N-1] arrays, shared with neuron and neuron TBs.
- One sub-module, vec_bank, stores one N-element bank. It has:
  - a single-element write port (idx, data, we);
  - a zero_from(idx) tail-clear strobe;
  - a parallel read-out.
- The top instantiates two vec_banks plus the fill/drain control.

Test Plan:
- Basic vector: reset, then stream -384,358,-77,2586,-384,358,-77,2586 with s_last on the 8th and m_ready=1. Expect m_valid high exactly 1 cycle after the 8th accept, m_vec equal to that order, and len_err=0.
- Backpressure: m_ready=0, stream 3 full vectors back to back. Expect 16 accepts, then s_ready=0 with vector 1 held stable on m_vec. Raise m_ready for 1 cycle: expect m_vec to switch to vector 2 and s_ready to return to 1 the next cycle.
- Short vector: stream 3072,7808,-2560 with s_last on the 3rd. Expect m_vec={3072,7808,-2560,0,0,0,0,0}, len_err pulsing exactly once, and fill_idx=0.
- Long vector: 8 elements with s_last=0, then 8 with s_last on the last. Expect 2 vectors, with len_err pulsing once (after the first).
- Sustained throughput: random s_valid gaps, m_ready=1, 100 vectors. Expect output order and values to match a scoreboard and no accept while s_ready=0.
- Reset mid-operation: assert rst after 5 elements of vector 2 while vector 1 is pending. Expect m_valid=0, s_ready=1, fill_idx=0 immediately (async), and the next 8 elements to form a clean vector.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron datapath and its stream front end.
package neuron_pkg;

   localparam int NEURON_WIDTH = 16;
   localparam int NEURON_N     = 8;

   typedef logic signed [NEURON_WIDTH-1:0] elem_t;
   typedef elem_t vec_t [0:NEURON_N-1];

   // A vector is well formed only when s_last lands exactly on the final slot.
   function automatic logic len_mismatch(input logic last, input logic at_end);
      return last ^ at_end;
   endfunction

endpackage

// File: rtl/vec_bank.sv
// One N-element vector bank: single-element write, tail clear from an index, parallel read-out.
// Latency: writes and clears visible on rd the cycle after the strobe.
// Backpressure: none; the owner decides when to write or clear.
module vec_bank #(
   parameter int WIDTH = 16,
   parameter int N     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [$clog2(N)-1:0]    idx,
   input  logic signed [WIDTH-1:0] data,
   input  logic                    clr,
   input  logic [$clog2(N)-1:0]    zero_from,
   output logic signed [WIDTH-1:0] rd [0:N-1]
);

   localparam int IW = $clog2(N);

   // The owner never points zero_from at or below idx in the same cycle, so write wins only nominally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) rd[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (we && idx == IW'(i))
               rd[i] <= data;
            else if (clr && i >= int'(zero_from))
               rd[i] <= '0;
         end
      end
   end

endmodule

// File: rtl/neuron_vec_loader.sv
// Assembles a serial element stream into N-wide vectors using two ping-pong banks.
// Latency: vector valid the cycle after its last element is accepted.
// Backpressure: s_ready drops only when both banks hold undrained vectors.
module neuron_vec_loader
   import neuron_pkg::*;
#(
   parameter int WIDTH = NEURON_WIDTH,
   parameter int N     = NEURON_N
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic signed [WIDTH-1:0] s_data,
   input  logic                    s_last,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic signed [WIDTH-1:0] m_vec [0:N-1],
   output logic                    len_err,
   output logic [$clog2(N)-1:0]    fill_idx
);

   localparam int IW = $clog2(N);

   logic          fill_bank;
   logic          out_bank;
   logic [1:0]    full;
   logic          acc;
   logic          at_end;
   logic          done;
   logic          short_vec;
   logic          drain;
   logic [IW-1:0] tail_from;

   logic signed [WIDTH-1:0] rd0 [0:N-1];
   logic signed [WIDTH-1:0] rd1 [0:N-1];

   assign s_ready   = !full[fill_bank];
   assign acc       = s_valid && s_ready;
   assign at_end    = (fill_idx == IW'(N-1));
   assign done      = acc && (at_end || s_last);
   assign short_vec = acc && s_last && !at_end;
   assign m_valid   = full[out_bank];
   assign drain     = m_valid && m_ready;
   assign tail_from = fill_idx + 1'b1;

   vec_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
      .clk       (clk),
      .rst       (rst),
      .we        (acc && !fill_bank),
      .idx       (fill_idx),
      .data      (s_data),
      .clr       (short_vec && !fill_bank),
      .zero_from (tail_from),
      .rd        (rd0)
   );

   vec_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
      .clk       (clk),
      .rst       (rst),
      .we        (acc && fill_bank),
      .idx       (fill_idx),
      .data      (s_data),
      .clr       (short_vec && fill_bank),
      .zero_from (tail_from),
      .rd        (rd1)
   );

   always_comb begin
      for (int i = 0; i < N; i++)
         m_vec[i] = out_bank ? rd1[i] : rd0[i];
   end

   // Completion and drain always target different banks: a full fill bank blocks accepts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_bank <= 1'b0;
         out_bank  <= 1'b0;
         full      <= 2'b00;
         fill_idx  <= '0;
         len_err   <= 1'b0;
      end else begin
         len_err <= acc && len_mismatch(s_last, at_end);
         if (acc)
            fill_idx <= done ? '0 : fill_idx + 1'b1;
         if (done) begin
            full[fill_bank] <= 1'b1;
            fill_bank       <= !fill_bank;
         end
         if (drain) begin
            full[out_bank] <= 1'b0;
            out_bank       <= !out_bank;
         end
      end
   end

endmodule

// File: tb/tb_neuron_vec_loader.sv
// Randomized bench for neuron_vec_loader against a queue-based vector model.
module tb_neuron_vec_loader;
   import neuron_pkg::*;

   localparam int W = NEURON_WIDTH;
   localparam int N = NEURON_N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic s_valid = 1'b0;
   logic s_ready;
   elem_t s_data = '0;
   logic s_last = 1'b0;
   logic m_valid;
   logic m_ready = 1'b0;
   elem_t m_vec [0:N-1];
   logic len_err;
   logic [$clog2(N)-1:0] fill_idx;

   int tests = 0;
   int fails = 0;

   vec_t  q_out[$];
   elem_t part[$];
   bit    exp_len_err = 1'b0;
   bit    rand_ready = 1'b0;

   neuron_vec_loader #(.WIDTH(W), .N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_vec    (m_vec),
      .len_err  (len_err),
      .fill_idx (fill_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("s_ready", s_ready, q_out.size() < 2);
      chk("m_valid", m_valid, q_out.size() > 0);
      chk("fill_idx", fill_idx, part.size());
      chk("len_err", len_err, exp_len_err);
      if (q_out.size() > 0)
         for (int i = 0; i < N; i++) chk("m_vec", m_vec[i], q_out[0][i]);
   endtask

   // One clock: drive at negedge, check, then advance the model at posedge.
   task automatic cyc(input logic v, input elem_t d, input logic l, input logic r, output bit acc);
      bit   drn;
      vec_t vv;
      s_valid = v;
      s_data  = d;
      s_last  = l;
      m_ready = r;
      #1;
      check_outputs();
      acc = v && (q_out.size() < 2);
      drn = (q_out.size() > 0) && r;
      @(posedge clk);
      exp_len_err = 1'b0;
      if (drn) void'(q_out.pop_front());
      if (acc) begin
         part.push_back(d);
         if (part.size() == N || l) begin
            exp_len_err = (part.size() != N) || !l;
            for (int i = 0; i < N; i++) vv[i] = (i < part.size()) ? part[i] : elem_t'(0);
            q_out.push_back(vv);
            part.delete();
         end
      end
      @(negedge clk);
   endtask

   task automatic push(input elem_t d, input logic l, input logic r);
      bit   a;
      int   n;
      logic re;
      n = 0;
      do begin
         re = rand_ready ? logic'($urandom_range(0, 1)) : r;
         cyc(1'b1, d, l, re, a);
         n++;
      end while (!a && n < 64);
      if (!a) chk("push_accept", a, 1);
   endtask

   task automatic idle(input int n, input logic r);
      bit a;
      repeat (n) cyc(1'b0, elem_t'($urandom), logic'($urandom_range(0, 1)), r, a);
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_fill_idx", fill_idx, 0);
      chk("rst_len_err", len_err, 0);
      q_out.delete();
      part.delete();
      exp_len_err = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      elem_t basic [0:7];
      elem_t held;
      bit    a;
      int    len;
      basic = '{-16'sd384, 16'sd358, -16'sd77, 16'sd2586, -16'sd384, 16'sd358, -16'sd77, 16'sd2586};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < N; i++) chk("rst_m_vec", m_vec[i], 0);

      // basic vector
      for (int i = 0; i < N; i++) push(basic[i], i == N - 1, 1'b1);
      idle(3, 1'b1);

      // backpressure: two vectors fill both banks, third waits for one drain
      for (int k = 0; k < 2 * N; k++) push(elem_t'($urandom), (k % N) == N - 1, 1'b0);
      held = elem_t'($urandom);
      repeat (3) cyc(1'b1, held, 1'b0, 1'b0, a);
      cyc(1'b1, held, 1'b0, 1'b1, a);
      push(held, 1'b0, 1'b0);
      for (int k = 1; k < N; k++) push(elem_t'($urandom), k == N - 1, 1'b0);
      idle(3, 1'b0);
      idle(4, 1'b1);

      // short vector
      push(16'sd3072, 1'b0, 1'b1);
      push(16'sd7808, 1'b0, 1'b1);
      push(-16'sd2560, 1'b1, 1'b1);
      idle(3, 1'b1);

      // long vector followed by a proper one
      for (int k = 0; k < 2 * N; k++) push(elem_t'($urandom), k == 2 * N - 1, 1'b1);
      idle(3, 1'b1);

      // sustained random traffic with gaps
      for (int v = 0; v < 100; v++)
         for (int e = 0; e < N; e++) begin
            idle($urandom_range(0, 2), 1'b1);
            push(elem_t'($urandom), e == N - 1, 1'b1);
         end
      idle(3, 1'b1);

      // random lengths and random downstream readiness
      rand_ready = 1'b1;
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, N + 2);
         for (int e = 0; e < len; e++) push(elem_t'($urandom), e == len - 1, 1'b0);
      end
      rand_ready = 1'b0;
      idle(6, 1'b1);

      // reset with one vector pending and another half filled
      for (int k = 0; k < N + 5; k++) push(elem_t'($urandom), k == N - 1, 1'b0);
      do_reset();
      for (int k = 0; k < N; k++) push(elem_t'($urandom), k == N - 1, 1'b0);
      idle(2, 1'b0);
      idle(3, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
